// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - cpu, host and RAM signal bundle for the data memory arbiter
interface dmem_arbiter_if #(
  parameter int AMSB = 7,
  parameter int DMSB = 7
);
  logic          cpu_req;
  logic          cpu_write;
  logic [AMSB:0] cpu_addr;
  logic [DMSB:0] cpu_wdata;
  logic [DMSB:0] cpu_rdata;
  logic          cpu_setn;

  logic          h_req;
  logic          h_write;
  logic [AMSB:0] h_addr;
  logic [DMSB:0] h_wdata;
  logic          h_gnt;
  logic [DMSB:0] h_rdata;
  logic          h_rvalid;

  logic          m_en;
  logic          m_we;
  logic [AMSB:0] m_addr;
  logic [DMSB:0] m_wdata;
  logic [DMSB:0] m_rdata;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_setn,
    input  h_req, h_write, h_addr, h_wdata,
    output h_gnt, h_rdata, h_rvalid,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // cpu/host/RAM environment side
  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_setn,
    output h_req, h_write, h_addr, h_wdata,
    input  h_gnt, h_rdata, h_rvalid,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin share of a 1-cycle-latency data RAM between cpu and host
module dmem_arbiter #(
  parameter int AMSB = 7,
  parameter int DMSB = 7
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CPU   = 2'd1,
    DONE_CPU = 2'd2,
    RD_HOST  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic          cpu_win, host_win;
  logic          m_en_c, m_we_c, h_gnt_c, setn_c;
  logic [AMSB:0] m_addr_c;
  logic [DMSB:0] m_wdata_c;
  logic [DMSB:0] cpu_rdata_q, h_rdata_q;
  logic          h_rvalid_q;

  // last=1 means the host was served most recently, so the cpu wins a tie
  assign cpu_win  = bus.cpu_req && (!bus.h_req || last);
  assign host_win = bus.h_req && !cpu_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      cpu_rdata_q <= '0;
      h_rdata_q   <= '0;
      h_rvalid_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      h_rvalid_q <= (state == RD_HOST);
      if (state == RD_CPU)
        cpu_rdata_q <= bus.m_rdata;
      if (state == RD_HOST)
        h_rdata_q <= bus.m_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    m_en_c    = 1'b0;
    m_we_c    = 1'b0;
    m_addr_c  = bus.cpu_addr;
    m_wdata_c = bus.cpu_wdata;
    h_gnt_c   = 1'b0;
    setn_c    = 1'b1;
    case (state)
      IDLE: begin
        if (cpu_win) begin
          m_en_c    = 1'b1;
          m_we_c    = bus.cpu_write;
          last_nxt  = 1'b0;
          setn_c    = bus.cpu_write;
          state_nxt = bus.cpu_write ? IDLE : RD_CPU;
        end else if (host_win) begin
          m_en_c    = 1'b1;
          m_we_c    = bus.h_write;
          m_addr_c  = bus.h_addr;
          m_wdata_c = bus.h_wdata;
          h_gnt_c   = 1'b1;
          last_nxt  = 1'b1;
          setn_c    = !bus.cpu_req;
          state_nxt = bus.h_write ? IDLE : RD_HOST;
        end
      end
      RD_CPU: begin
        setn_c    = 1'b0;
        state_nxt = DONE_CPU;
      end
      DONE_CPU: begin
        state_nxt = IDLE;
      end
      RD_HOST: begin
        setn_c    = !bus.cpu_req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // keep the RAM quiet and the cpu stalled for as long as reset is held
    if (rst) begin
      m_en_c  = 1'b0;
      m_we_c  = 1'b0;
      h_gnt_c = 1'b0;
      setn_c  = 1'b0;
    end
  end

  assign bus.m_en      = m_en_c;
  assign bus.m_we      = m_we_c;
  assign bus.m_addr    = m_addr_c;
  assign bus.m_wdata   = m_wdata_c;
  assign bus.h_gnt     = h_gnt_c;
  assign bus.cpu_setn  = setn_c;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.h_rvalid  = h_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - cycle-table and alternation checks for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  dmem_arbiter_if #(.AMSB(7), .DMSB(7)) bus ();

  dmem_arbiter #(.AMSB(7), .DMSB(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM with 1-cycle read latency
  logic [7:0] mem [0:255] = '{default: 8'h00};
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          ram_q <= mem[bus.m_addr];
    end
  end
  assign bus.m_rdata = ram_q;

  typedef struct {
    logic       rst, creq, cwr;
    logic [7:0] caddr, cwd;
    logic       hreq, hwr;
    logic [7:0] haddr, hwd;
    logic       e_setn, e_gnt, e_en, e_we;
    logic [7:0] e_addr;
    logic       e_rv;
    logic [7:0] e_crd, e_hrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic cq, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
    input logic hq, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
    input logic s, input logic g, input logic en, input logic we, input logic [7:0] ad,
    input logic rv, input logic [7:0] crd, input logic [7:0] hrd);
    vec_t v;
    v.rst = r; v.creq = cq; v.cwr = cw; v.caddr = ca; v.cwd = cd;
    v.hreq = hq; v.hwr = hw; v.haddr = ha; v.hwd = hd;
    v.e_setn = s; v.e_gnt = g; v.e_en = en; v.e_we = we; v.e_addr = ad;
    v.e_rv = rv; v.e_crd = crd; v.e_hrd = hrd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.cpu_req   = v.creq;
    bus.cpu_write = v.cwr;
    bus.cpu_addr  = v.caddr;
    bus.cpu_wdata = v.cwd;
    bus.h_req     = v.hreq;
    bus.h_write   = v.hwr;
    bus.h_addr    = v.haddr;
    bus.h_wdata   = v.hwd;
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
    bus.h_req = 1'b0; bus.h_write = 1'b0; bus.h_addr = 8'h00; bus.h_wdata = 8'h00;

    //            rst cq cw caddr  cwd    hq hw haddr  hwd   | setn gnt en we addr  rv crd    hrd
    vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,0,8'h00, 0,8'h00,8'h00)); // in reset
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 1,1,8'h10,8'h5A, 0,0,8'h00,8'h00,  1,0,1,1,8'h10, 0,8'h00,8'h00)); // cpu write
    vecs.push_back(mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,  0,0,1,0,8'h10, 0,8'h00,8'h00)); // cpu read
    vecs.push_back(mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,  0,0,0,0,8'h00, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h5A,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,1,8'h20,8'hC3,  1,1,1,1,8'h20, 0,8'h5A,8'h00)); // host write
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00,  1,1,1,0,8'h20, 0,8'h5A,8'h00)); // host read
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h5A,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 1,8'h5A,8'hC3));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h5A,8'hC3));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00,  1,1,1,0,8'h10, 0,8'h5A,8'hC3)); // host stream
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00,  1,0,0,0,8'h00, 0,8'h5A,8'hC3));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00,  1,1,1,0,8'h20, 1,8'h5A,8'h5A));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h5A,8'h5A));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 1,8'h5A,8'hC3));
    vecs.push_back(mk(0, 1,0,8'h20,8'h00, 1,1,8'h30,8'h77,  0,0,1,0,8'h20, 0,8'h5A,8'hC3)); // contention
    vecs.push_back(mk(0, 1,0,8'h20,8'h00, 1,1,8'h30,8'h77,  0,0,0,0,8'h00, 0,8'h5A,8'hC3));
    vecs.push_back(mk(0, 1,0,8'h20,8'h00, 1,1,8'h30,8'h77,  1,0,0,0,8'h00, 0,8'hC3,8'hC3));
    vecs.push_back(mk(0, 1,1,8'h40,8'h11, 1,1,8'h30,8'h77,  0,1,1,1,8'h30, 0,8'hC3,8'hC3));
    vecs.push_back(mk(0, 1,1,8'h40,8'h11, 0,0,8'h00,8'h00,  1,0,1,1,8'h40, 0,8'hC3,8'hC3));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h40,8'h00,  1,1,1,0,8'h40, 0,8'hC3,8'hC3));
    vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,0,8'h00, 0,8'h00,8'h00)); // reset in RD_HOST
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 1,1,8'h50,8'h01, 1,1,8'h60,8'h02,  1,0,1,1,8'h50, 0,8'h00,8'h00)); // tie after reset
    vecs.push_back(mk(0, 1,1,8'h50,8'h01, 1,1,8'h60,8'h02,  0,1,1,1,8'h60, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 1,1,8'h50,8'h01, 1,1,8'h61,8'h03,  1,0,1,1,8'h50, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 1,1,8'h52,8'h04, 1,1,8'h61,8'h03,  0,1,1,1,8'h61, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00,  1,1,1,0,8'h20, 0,8'h00,8'h00));
    vecs.push_back(mk(0, 1,1,8'h50,8'h05, 0,0,8'h00,8'h00,  0,0,0,0,8'h00, 0,8'h00,8'h00)); // cpu stalled in RD_HOST
    vecs.push_back(mk(0, 1,1,8'h50,8'h05, 0,0,8'h00,8'h00,  1,0,1,1,8'h50, 1,8'h00,8'hC3));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,0,8'h00, 0,8'h00,8'hC3));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk("cpu_setn",  i, {7'd0, bus.cpu_setn}, {7'd0, vecs[i].e_setn});
      chk("h_gnt",     i, {7'd0, bus.h_gnt},    {7'd0, vecs[i].e_gnt});
      chk("m_en",      i, {7'd0, bus.m_en},     {7'd0, vecs[i].e_en});
      if (vecs[i].e_en) begin
        chk("m_we",    i, {7'd0, bus.m_we},     {7'd0, vecs[i].e_we});
        chk("m_addr",  i, bus.m_addr,           vecs[i].e_addr);
      end
      chk("h_rvalid",  i, {7'd0, bus.h_rvalid}, {7'd0, vecs[i].e_rv});
      chk("cpu_rdata", i, bus.cpu_rdata,        vecs[i].e_crd);
      chk("h_rdata",   i, bus.h_rdata,          vecs[i].e_hrd);
    end

    // both sides issue reads continuously from reset: grants must go cpu, host, cpu, host ...
    begin
      logic exp_host;
      int   issued;
      int   budget;
      @(negedge clk);
      rst = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h20;
      bus.h_req = 1'b1;   bus.h_write = 1'b0;   bus.h_addr = 8'h10;
      @(negedge clk);
      rst = 1'b0;
      exp_host = 1'b0;
      issued = 0;
      budget = 0;
      while (issued < 6 && budget < 40) begin
        #2;
        if (bus.m_en) begin
          chk("alt_winner", issued, {7'd0, bus.h_gnt}, {7'd0, exp_host});
          chk("alt_addr",   issued, bus.m_addr, exp_host ? 8'h10 : 8'h20);
          exp_host = !exp_host;
          issued++;
        end
        budget++;
        @(negedge clk);
      end
      chk("alt_issue_count", budget, issued[7:0], 8'd6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
